// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit 7-segment scanner: active-high segment
// codes in {g,f,e,d,c,b,a} order and the slot encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic SLOT_ONES = 1'b0;
  localparam logic SLOT_TENS = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-high 7-segment decoder; non-BCD codes show a dash so a bad
// digit is visible on the display rather than silently blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed 7-segment driver: refresh prescaler, per-frame shadow
// capture of both digits, leading-zero blanking and registered pin outputs.
module seg7_scan_2digit
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       Clk,
  input  logic       R,
  input  logic       En,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       Frame
);

  localparam int          PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_INV  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  AN_INV   = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [PW-1:0] pre_p0;
  logic          slot_p0;
  logic [3:0]    shadow0_p0;
  logic [3:0]    shadow1_p0;
  logic          tick;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic [1:0]    an_nxt;

  assign tick = (pre_p0 == PRE_LAST);

  // stage p0: prescaler, slot and frame-coherent digit capture
  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      pre_p0     <= '0;
      slot_p0    <= SLOT_ONES;
      shadow0_p0 <= 4'd0;
      shadow1_p0 <= 4'd0;
      Frame      <= 1'b0;
    end else begin
      pre_p0 <= tick ? '0 : pre_p0 + PW'(1);
      if (tick) slot_p0 <= ~slot_p0;
      if (tick && slot_p0 == SLOT_TENS) begin
        shadow0_p0 <= D0;
        shadow1_p0 <= D1;
      end
      Frame <= tick && (slot_p0 == SLOT_TENS);
    end
  end

  assign digit = (slot_p0 == SLOT_TENS) ? shadow1_p0 : shadow0_p0;

  seg7_decode u_decode (
    .digit (digit),
    .seg   (seg_dec)
  );

  always_comb begin
    an_nxt = 2'b00;
    if (En) begin
      if (slot_p0 == SLOT_ONES)
        an_nxt[0] = 1'b1;
      else if (!(BLANK_LEADING && shadow1_p0 == 4'd0))
        an_nxt[1] = 1'b1;
    end
  end

  // stage p1: registered pins with board polarity applied
  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      SEG <= SEG_BLANK ^ SEG_INV;
      AN  <= AN_INV;
    end else begin
      SEG <= seg_dec ^ SEG_INV;
      AN  <= an_nxt ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Directed bench for seg7_scan_2digit: three instances (blanking active-high,
// no blanking active-high, blanking active-low) driven from shared inputs.
module tb_seg7_scan_2digit;

  logic       Clk = 1'b0;
  logic       R;
  logic       En;
  logic [3:0] D0;
  logic [3:0] D1;

  logic [6:0] seg_hi, seg_nb, seg_lo;
  logic [1:0] an_hi, an_nb, an_lo;
  logic       frame_hi, frame_nb, frame_lo;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  always #5 Clk = ~Clk;

  seg7_scan_2digit #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_hi (
    .Clk(Clk), .R(R), .En(En), .D0(D0), .D1(D1),
    .SEG(seg_hi), .AN(an_hi), .Frame(frame_hi)
  );

  seg7_scan_2digit #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_nb (
    .Clk(Clk), .R(R), .En(En), .D0(D0), .D1(D1),
    .SEG(seg_nb), .AN(an_nb), .Frame(frame_nb)
  );

  seg7_scan_2digit #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_lo (
    .Clk(Clk), .R(R), .En(En), .D0(D0), .D1(D1),
    .SEG(seg_lo), .AN(an_lo), .Frame(frame_lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where Frame is seen high; walks the next 8 cycles
  // (ones slot then tens slot) and ends on the following Frame pulse.
  // Inputs are changed to c0/c1 mid-frame, so they load at the frame end.
  task automatic scan(input string tag, input logic [6:0] s1, input logic [6:0] s10,
                      input logic [1:0] an10, input logic [3:0] c0, input logic [3:0] c1);
    logic [6:0] es, esl;
    logic [1:0] ea, eal, ean;
    logic       ef;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      es  = (i > 4) ? s10 : s1;
      ea  = (i > 4) ? an10 : 2'b01;
      ean = (i > 4) ? 2'b10 : 2'b01;
      esl = ~es;
      eal = ~ea;
      ef  = (i == 8);
      check({tag, "_seg_hi"}, seg_hi, es);
      check({tag, "_an_hi"}, an_hi, ea);
      check({tag, "_seg_nb"}, seg_nb, es);
      check({tag, "_an_nb"}, an_nb, ean);
      check({tag, "_seg_lo"}, seg_lo, esl);
      check({tag, "_an_lo"}, an_lo, eal);
      check({tag, "_frame_hi"}, frame_hi, ef);
      check({tag, "_frame_lo"}, frame_lo, ef);
      if (i == 3) begin
        D0 = c0;
        D1 = c1;
      end
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_hi !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_frame_wait"}, frame_hi, 1'b1);
  endtask

  initial begin
    logic [3:0] cur0, cur1;
    R  = 1'b1;
    En = 1'b1;
    D0 = 4'd7;
    D1 = 4'd3;
    repeat (3) @(negedge Clk);
    check("rst_seg_hi", seg_hi, 7'h00);
    check("rst_an_hi", an_hi, 2'b00);
    check("rst_frame", frame_hi, 1'b0);
    check("rst_seg_lo", seg_lo, 7'h7F);
    check("rst_an_lo", an_lo, 2'b11);
    R = 1'b0;

    // shadow starts at 0: ones shows 0, tens blanked; first load at cycle 8
    scan("boot", 7'h3F, 7'h3F, 2'b00, 4'd7, 4'd3);
    scan("scan_a", 7'h07, 7'h4F, 2'b10, 4'd7, 4'd3);
    scan("scan_b", 7'h07, 7'h4F, 2'b10, 4'd2, 4'd1);
    scan("coh_old", 7'h5B, 7'h06, 2'b10, 4'd5, 4'd8);
    scan("coh_new", 7'h6D, 7'h7F, 2'b10, 4'd4, 4'd0);
    scan("lz", 7'h66, 7'h3F, 2'b00, 4'd4, 4'd0);

    En = 1'b0;
    D0 = 4'd12;
    D1 = 4'd9;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      check("en_off_an_hi", an_hi, 2'b00);
      check("en_off_an_nb", an_nb, 2'b00);
      check("en_off_an_lo", an_lo, 2'b11);
      check("en_off_frame", frame_hi, (i == 8));
    end
    En = 1'b1;
    @(negedge Clk);
    wait_frame("en_on");
    scan("err", 7'h40, 7'h6F, 2'b10, 4'd12, 4'd9);

    cur0 = 4'd12;
    cur1 = 4'd9;
    for (int v = 0; v < 16; v++) begin
      scan("sweep", seg_tab[cur0], seg_tab[cur1], (cur1 == 4'd0) ? 2'b00 : 2'b10,
           4'(v), 4'(15 - v));
      cur0 = 4'(v);
      cur1 = 4'(15 - v);
    end
    scan("sweep_last", seg_tab[cur0], seg_tab[cur1], (cur1 == 4'd0) ? 2'b00 : 2'b10,
         cur0, cur1);

    // asynchronous reset while Frame is high, between clock edges
    #2 R = 1'b1;
    #1;
    check("mid_rst_seg_hi", seg_hi, 7'h00);
    check("mid_rst_an_hi", an_hi, 2'b00);
    check("mid_rst_an_nb", an_nb, 2'b00);
    check("mid_rst_frame", frame_hi, 1'b0);
    check("mid_rst_seg_lo", seg_lo, 7'h7F);
    check("mid_rst_an_lo", an_lo, 2'b11);
    @(negedge Clk);
    R = 1'b0;
    scan("post_rst", 7'h3F, 7'h3F, 2'b00, 4'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_2digit.md
Name: seg7_scan_2digit

Overview:
Downstream display stage for the two-digit BCD counter.
- Consumes the ones digit and tens digit from two cascaded 1-digit BCD counters.
- Time-multiplexes both digits onto one shared 7-segment bus with per-digit anode enables.
- Contains a refresh prescaler, a frame-coherent shadow register, leading-zero blanking and registered outputs.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range ≥2; prescaler width = clog2(REFRESH_DIV).
ACTIVE_LOW, 1, 1 = SEG and AN driven active-low (common-anode board); 0 = active-high.
BLANK_LEADING, 1, 1 = tens digit blanked when its value is 0.

Ports:
Clk  input  1  system clock; all state on rising edge.
R  input  1  reset; asynchronous, active-high.
En  input  1  display enable; 0 = all anodes inactive, scanning continues.
D0  input  4  ones digit, BCD 0-9.
D1  input  4  tens digit, BCD 0-9.
SEG  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
AN  output  2  digit enables; AN[0] = ones, AN[1] = tens; polarity per ACTIVE_LOW.
Frame  output  1  one-cycle pulse in the cycle the shadow register loads.

Behaviour:
- Reset (R=1, asynchronous):
  - prescaler=0, slot=0, shadow0=shadow1=0, Frame=0.
  - SEG and AN registers at their inactive level: all segments off, both anodes off. Actual pin levels are all-ones if ACTIVE_LOW=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, wrapping to 0.
  - tick=1 combinationally when prescaler==REFRESH_DIV-1.
- Slot:
  - 1-bit; toggles on tick; 0 = ones, 1 = tens.
- Shadow load:
  - When tick && slot==1 (slot about to return to 0), capture shadow0<=D0 and shadow1<=D1. Frame=1 in that same cycle (registered, visible the next cycle).
  - Guarantees both digits shown within one frame come from the same sample; D0/D1 changes mid-frame are ignored until the next boundary.
  - First load occurs 2*REFRESH_DIV cycles after reset release. Until then the display shows 0, with tens blanked if BLANK_LEADING=1.
- Output register (updates every cycle, 1-cycle latency from slot/shadow/En):
  - digit = slot ? shadow1 : shadow0.
  - SEG = decode(digit).
  - AN active for the slot digit only.
  - Force AN inactive for both digits if En=0.
  - Force AN inactive for the tens digit if slot==1 && BLANK_LEADING && shadow1==0.
  - SEG still carries the decoded value when its anode is forced off.
  - Never both anodes active in the same cycle.
- Decode (active-high internal form, then inverted if ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10-15 -> dash 40 (g only), used as an error indicator.
- Simultaneous events: a D0/D1 change in the load cycle is captured (sampled on that edge).
- En toggling: takes effect on AN the next cycle; does not disturb prescaler, slot or shadow.
- Reset mid-frame: immediate blanking; the scan restarts at slot 0 with prescaler 0.

Decomposition:
- Package seg7_pkg:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (7-bit, active-high);
  - slot encoding constants SLOT_ONES=0, SLOT_TENS=1.
- Sub-module seg7_decode: combinational 4-bit BCD -> 7-bit active-high segments using the package constants; instantiated once.
- Polarity inversion and all registers stay in seg7_scan_2digit.

Test Plan:
- Reset check: REFRESH_DIV=4, assert R mid-cycle -> SEG/AN inactive immediately without waiting for a clock edge; Frame=0; after release, AN[0] active on the first edge with SEG=3F (internal form).
- Scan timing: REFRESH_DIV=4, D0=7, D1=3, En=1.
  - Frame pulses every 8 cycles.
  - After the first Frame, AN alternates ones/tens every 4 cycles with SEG=07 then 4F.
  - AN is never both active.
- Frame coherence: change D0 from 2 to 5 and D1 from 1 to 8 mid-frame -> current frame still shows 5B/06; new values 6D/7F appear only after the next Frame pulse.
- Leading-zero blanking: D1=0, D0=4, BLANK_LEADING=1 -> tens anode stays off during the tens slot while ones shows 66.
  - Same stimulus with BLANK_LEADING=0 -> tens shows 3F.
- Enable and error code: En=0 for 10 cycles -> both anodes off while Frame keeps pulsing every 8 cycles. Then D0=12 with En=1 -> ones slot shows 40.
- Polarity: ACTIVE_LOW=1, D0=8 -> SEG pins = 0000000 and active AN bit = 0.
